// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - timing defaults, palette defaults and shared types for the VGA scan engine
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 29;

  typedef logic [7:0] rgb332_t;

  // One slot of the delay line that keeps sync/blank aligned with the colour path.
  typedef struct packed {
    logic hs;
    logic vs;
    logic vb;
    logic fs;
    logic win;
  } scan_tap_t;

  localparam scan_tap_t TAP_IDLE = '{hs: 1'b0, vs: 1'b0, vb: 1'b1, fs: 1'b0, win: 1'b0};

  localparam rgb332_t DEFAULT_PAL [8] = '{
    8'hBB, 8'hEC, 8'h96, 8'hF8, 8'hF8, 8'h92, 8'h82, 8'h92
  };

  function automatic rgb332_t pal_default(input int idx);
    return DEFAULT_PAL[idx & 7];
  endfunction

endpackage

// File: rtl/vga_scan_engine_if.sv
// rtl/vga_scan_engine_if.sv - framebuffer read port, palette write port and VGA pin bundle
interface vga_scan_engine_if #(
  parameter int ADDR_W = 16,
  parameter int CODE_W = 3
);
  logic [ADDR_W-1:0] rmemaddr;
  logic [CODE_W-1:0] memout;
  logic              pal_we;
  logic [CODE_W-1:0] pal_waddr;
  logic [7:0]        pal_wdata;
  logic              hsync;
  logic              vsync;
  logic [2:0]        red;
  logic [2:0]        green;
  logic [1:0]        blue;
  logic              vblank;
  logic              frame_start;

  modport master (
    output rmemaddr, hsync, vsync, red, green, blue, vblank, frame_start,
    input  memout, pal_we, pal_waddr, pal_wdata
  );

  modport slave (
    input  rmemaddr, hsync, vsync, red, green, blue, vblank, frame_start,
    output memout, pal_we, pal_waddr, pal_wdata
  );
endinterface

// File: rtl/vga_palette.sv
// rtl/vga_palette.sv - run-time writable colour palette with reset defaults
module vga_palette
  import vga_pkg::*;
#(
  parameter int CODE_W = 3
) (
  input  logic              dclk,
  input  logic              clr,
  input  logic              we,
  input  logic [CODE_W-1:0] waddr,
  input  rgb332_t           wdata,
  input  logic [CODE_W-1:0] raddr,
  output rgb332_t           rdata
);
  localparam int N = 1 << CODE_W;

  rgb332_t mem [N];

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < N; i++) begin
        mem[i] <= pal_default(i);
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read sees the pre-write value during a write cycle.
  assign rdata = mem[raddr];

endmodule

// File: rtl/vga_scan_engine.sv
// rtl/vga_scan_engine.sv - parametrised VGA timing, scaled window address generator and aligned colour output
module vga_scan_engine
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter bit SYNC_POL   = 1'b0,
  parameter int SCALE_LOG2 = 2,
  parameter int WIN_W      = 160,
  parameter int WIN_H      = 120,
  parameter int ADDR_W     = 16,
  parameter int CODE_W     = 3,
  parameter int RD_LAT     = 1
) (
  input  logic dclk,
  input  logic clr,
  vga_scan_engine_if.master bus
);
  localparam int H_TOTAL  = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int WIN_PX_W = WIN_W << SCALE_LOG2;
  localparam int WIN_PX_H = WIN_H << SCALE_LOG2;
  localparam int X0       = H_SYNC + H_BP + (H_ACTIVE - WIN_PX_W) / 2;
  localparam int Y0       = V_SYNC + V_BP + (V_ACTIVE - WIN_PX_H) / 2;
  localparam int HW       = $clog2(H_TOTAL + 1);
  localparam int VW       = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
  localparam logic [HW-1:0] X0_C       = HW'(X0);
  localparam logic [HW-1:0] X1_C       = HW'(X0 + WIN_PX_W);
  localparam logic [HW-1:0] X_LAST_C   = HW'(X0 + WIN_PX_W - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
  localparam logic [VW-1:0] VA0_C      = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] VA1_C      = VW'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [VW-1:0] Y0_C       = VW'(Y0);
  localparam logic [VW-1:0] Y1_C       = VW'(Y0 + WIN_PX_H);
  localparam logic [7:0]    SUB_MAX    = 8'((1 << SCALE_LOG2) - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(WIN_W);

  if (WIN_PX_W > H_ACTIVE) begin : g_err_win_w
    $error("vga_scan_engine: scaled window wider than the active line");
  end
  if (WIN_PX_H > V_ACTIVE) begin : g_err_win_h
    $error("vga_scan_engine: scaled window taller than the active frame");
  end
  if (longint'(WIN_W) * longint'(WIN_H) > (longint'(1) << ADDR_W)) begin : g_err_addr
    $error("vga_scan_engine: window does not fit the framebuffer address space");
  end
  if (RD_LAT < 0 || RD_LAT > 3) begin : g_err_lat
    $error("vga_scan_engine: framebuffer read latency out of range");
  end

  logic [HW-1:0] hc;
  logic [VW-1:0] vc;

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == H_LAST) begin
      hc <= '0;
      vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
    end else begin
      hc <= hc + 1'b1;
    end
  end

  logic      win_raw;
  logic      line_end;
  logic      frame_end;
  scan_tap_t tap_raw;

  always_comb begin
    tap_raw     = TAP_IDLE;
    win_raw     = (hc >= X0_C) && (hc < X1_C) && (vc >= Y0_C) && (vc < Y1_C);
    tap_raw.hs  = (hc < H_SYNC_END);
    tap_raw.vs  = (vc < V_SYNC_END);
    tap_raw.vb  = (vc < VA0_C) || (vc >= VA1_C);
    tap_raw.fs  = (hc == '0) && (vc == '0);
    tap_raw.win = win_raw;
    line_end    = win_raw && (hc == X_LAST_C);
    frame_end   = (hc == H_LAST) && (vc == V_LAST);
  end

  // Address = row_base + col, stepped by counting sub-pixels instead of multiplying.
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] col;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        sub_x;
  logic [7:0]        sub_y;

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      row_base <= '0;
      col      <= '0;
      addr_q   <= '0;
      sub_x    <= '0;
      sub_y    <= '0;
    end else begin
      if (win_raw) begin
        addr_q <= row_base + col;
        if (sub_x == SUB_MAX) begin
          sub_x <= '0;
          col   <= col + 1'b1;
        end else begin
          sub_x <= sub_x + 1'b1;
        end
      end
      if (line_end) begin
        col   <= '0;
        sub_x <= '0;
        if (sub_y == SUB_MAX) begin
          sub_y    <= '0;
          row_base <= row_base + ROW_STEP;
        end else begin
          sub_y <= sub_y + 1'b1;
        end
      end
      if (frame_end) begin
        row_base <= '0;
        col      <= '0;
        sub_x    <= '0;
        sub_y    <= '0;
      end
    end
  end

  // RD_LAT+1 taps bring the flags level with the palette read; the output stage adds one more.
  scan_tap_t dly [RD_LAT+1];

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i <= RD_LAT; i++) begin
        dly[i] <= TAP_IDLE;
      end
    end else begin
      dly[0] <= tap_raw;
      for (int i = 1; i <= RD_LAT; i++) begin
        dly[i] <= dly[i-1];
      end
    end
  end

  rgb332_t pal_rdata;

  vga_palette #(
    .CODE_W(CODE_W)
  ) u_pal (
    .dclk  (dclk),
    .clr   (clr),
    .we    (bus.pal_we),
    .waddr (bus.pal_waddr),
    .wdata (bus.pal_wdata),
    .raddr (bus.memout),
    .rdata (pal_rdata)
  );

  logic    hsync_q;
  logic    vsync_q;
  logic    vblank_q;
  logic    fs_q;
  rgb332_t rgb_q;

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      hsync_q  <= ~SYNC_POL;
      vsync_q  <= ~SYNC_POL;
      vblank_q <= 1'b1;
      fs_q     <= 1'b0;
      rgb_q    <= '0;
    end else begin
      hsync_q  <= dly[RD_LAT].hs ? SYNC_POL : ~SYNC_POL;
      vsync_q  <= dly[RD_LAT].vs ? SYNC_POL : ~SYNC_POL;
      vblank_q <= dly[RD_LAT].vb;
      fs_q     <= dly[RD_LAT].fs;
      rgb_q    <= dly[RD_LAT].win ? pal_rdata : '0;
    end
  end

  assign bus.rmemaddr    = addr_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.vblank      = vblank_q;
  assign bus.frame_start = fs_q;
  assign bus.red         = rgb_q[7:5];
  assign bus.green       = rgb_q[4:2];
  assign bus.blue        = rgb_q[1:0];

endmodule

// File: tb/tb_vga_scan_engine.sv
// tb/tb_vga_scan_engine.sv - directed vector bench for default and reduced-timing scan engines
module tb_vga_scan_engine;

  logic dclk = 1'b0;
  always #5 dclk = ~dclk;

  logic clr_a;
  logic clr_b;

  vga_scan_engine_if #(.ADDR_W(16), .CODE_W(3)) bus_a ();
  vga_scan_engine_if #(.ADDR_W(8),  .CODE_W(3)) bus_b ();

  vga_scan_engine u_a (
    .dclk (dclk),
    .clr  (clr_a),
    .bus  (bus_a)
  );

  // Small 41x29 raster, 2x scale, 8x6 window, active-high sync, 3-cycle memory.
  vga_scan_engine #(
    .H_ACTIVE(32), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(24), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b1), .SCALE_LOG2(1), .WIN_W(8), .WIN_H(6),
    .ADDR_W(8), .CODE_W(3), .RD_LAT(3)
  ) u_b (
    .dclk (dclk),
    .clr  (clr_b),
    .bus  (bus_b)
  );

  always @(posedge dclk) bus_a.memout <= bus_a.rmemaddr[2:0];

  logic [2:0] b_p0;
  logic [2:0] b_p1;
  always @(posedge dclk) begin
    b_p0         <= bus_b.rmemaddr[2:0];
    b_p1         <= b_p0;
    bus_b.memout <= b_p1;
  end

  typedef enum int {SIG_HS, SIG_VS, SIG_VB, SIG_FS, SIG_RGB, SIG_ADDR} sig_e;

  typedef struct {
    int   cyc;
    int   dut;
    sig_e sig;
    int   exp;
  } vec_t;

  vec_t tab [$];
  int   checks = 0;
  int   errors = 0;
  int   n = 0;

  function automatic int read_sig(input int dut, input sig_e s);
    if (dut == 0) begin
      case (s)
        SIG_HS:   return int'(bus_a.hsync);
        SIG_VS:   return int'(bus_a.vsync);
        SIG_VB:   return int'(bus_a.vblank);
        SIG_FS:   return int'(bus_a.frame_start);
        SIG_RGB:  return int'({bus_a.red, bus_a.green, bus_a.blue});
        default:  return int'(bus_a.rmemaddr);
      endcase
    end
    case (s)
      SIG_HS:   return int'(bus_b.hsync);
      SIG_VS:   return int'(bus_b.vsync);
      SIG_VB:   return int'(bus_b.vblank);
      SIG_FS:   return int'(bus_b.frame_start);
      SIG_RGB:  return int'({bus_b.red, bus_b.green, bus_b.blue});
      default:  return int'(bus_b.rmemaddr);
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge dclk);
    n++;
  endtask

  task automatic run_to(input int target);
    while (n < target) tick();
  endtask

  function automatic void add(input int c, input int d, input sig_e s, input int e);
    vec_t v;
    v.cyc = c; v.dut = d; v.sig = s; v.exp = e;
    tab.push_back(v);
  endfunction

  initial begin
    clr_a = 1'b1;
    clr_b = 1'b1;
    bus_a.pal_we = 1'b0; bus_a.pal_waddr = '0; bus_a.pal_wdata = '0;
    bus_b.pal_we = 1'b0; bus_b.pal_waddr = '0; bus_b.pal_wdata = '0;

    // cycle = posedges since clr fell; outputs show counter stage cycle-L, rmemaddr stage cycle-1
    add(2, 0, SIG_HS, 1);      add(2, 0, SIG_FS, 0);
    add(3, 0, SIG_HS, 0);      add(3, 0, SIG_FS, 1);      add(3, 0, SIG_VB, 1);
    add(4, 1, SIG_HS, 0);      add(4, 0, SIG_FS, 0);
    add(5, 1, SIG_HS, 1);      add(5, 1, SIG_FS, 1);
    add(8, 1, SIG_HS, 1);      add(9, 1, SIG_HS, 0);
    add(86, 1, SIG_VS, 1);     add(87, 1, SIG_VS, 0);
    add(98, 0, SIG_HS, 0);     add(99, 0, SIG_HS, 1);
    add(168, 1, SIG_VB, 1);    add(169, 1, SIG_VB, 0);
    add(428, 1, SIG_ADDR, 1);
    add(429, 1, SIG_RGB, 0);   add(430, 1, SIG_RGB, 'hBB);
    add(441, 1, SIG_ADDR, 7);
    add(445, 1, SIG_RGB, 'h92); add(446, 1, SIG_RGB, 0);
    add(467, 1, SIG_ADDR, 0);  add(469, 1, SIG_ADDR, 1);
    add(508, 1, SIG_ADDR, 8);  add(512, 1, SIG_RGB, 'hBB);
    add(802, 0, SIG_HS, 1);    add(803, 0, SIG_HS, 0);
    add(892, 1, SIG_ADDR, 47);
    add(927, 1, SIG_RGB, 0);   add(927, 1, SIG_VB, 0);
    add(1000, 1, SIG_ADDR, 47);
    add(1152, 1, SIG_VB, 0);   add(1153, 1, SIG_VB, 1);
    add(1193, 1, SIG_FS, 0);   add(1194, 1, SIG_FS, 1);
    add(1602, 0, SIG_VS, 0);   add(1603, 0, SIG_VS, 1);
    add(1615, 1, SIG_ADDR, 0);
    add(24802, 0, SIG_VB, 1);  add(24803, 0, SIG_VB, 0);
    add(24945, 0, SIG_ADDR, 0);
    add(24946, 0, SIG_RGB, 0); add(24947, 0, SIG_RGB, 'hBB);
    add(24948, 0, SIG_ADDR, 0); add(24949, 0, SIG_ADDR, 1);
    add(24951, 0, SIG_RGB, 'hEC); add(24955, 0, SIG_RGB, 'h96);
    add(25584, 0, SIG_ADDR, 159);
    add(25586, 0, SIG_RGB, 'h92); add(25587, 0, SIG_RGB, 0);
    add(25601, 0, SIG_ADDR, 159);
    add(25745, 0, SIG_ADDR, 0); add(27345, 0, SIG_ADDR, 0);
    add(28145, 0, SIG_ADDR, 160); add(28149, 0, SIG_ADDR, 161);

    repeat (3) @(negedge dclk);
    check("a_rst_hsync", int'(bus_a.hsync), 1);
    check("a_rst_vsync", int'(bus_a.vsync), 1);
    check("a_rst_vblank", int'(bus_a.vblank), 1);
    check("a_rst_fs", int'(bus_a.frame_start), 0);
    check("a_rst_rgb", read_sig(0, SIG_RGB), 0);
    check("a_rst_addr", read_sig(0, SIG_ADDR), 0);
    check("b_rst_hsync", int'(bus_b.hsync), 0);
    check("b_rst_vsync", int'(bus_b.vsync), 0);

    clr_a = 1'b0;
    clr_b = 1'b0;
    n = 0;

    foreach (tab[i]) begin
      run_to(tab[i].cyc);
      check($sformatf("dut%0d_%s_at_%0d", tab[i].dut, tab[i].sig.name(), tab[i].cyc),
            read_sig(tab[i].dut, tab[i].sig), tab[i].exp);
    end

    // Restart B, then hit it with clr in the middle of the window.
    clr_b = 1'b1;
    @(negedge dclk);
    clr_b = 1'b0;
    n = 0;
    run_to(517);
    check("b_mid_rgb", read_sig(1, SIG_RGB), 'h96);
    check("b_mid_vblank", read_sig(1, SIG_VB), 0);
    #2 clr_b = 1'b1;
    #1;
    check("b_clr_rgb", read_sig(1, SIG_RGB), 0);
    check("b_clr_vblank", read_sig(1, SIG_VB), 1);
    check("b_clr_addr", read_sig(1, SIG_ADDR), 0);
    check("b_clr_hsync", read_sig(1, SIG_HS), 0);
    check("b_clr_fs", read_sig(1, SIG_FS), 0);
    @(negedge dclk);
    @(negedge dclk);
    clr_b = 1'b0;
    n = 0;
    run_to(4);
    check("b_restart_fs_early", read_sig(1, SIG_FS), 0);
    run_to(5);
    check("b_restart_fs", read_sig(1, SIG_FS), 1);
    check("b_restart_hsync", read_sig(1, SIG_HS), 1);
    run_to(428);
    check("b_restart_addr", read_sig(1, SIG_ADDR), 1);

    // Overwrite entry 0 while its old value is being read for the first window pixel.
    run_to(429);
    bus_b.pal_we    = 1'b1;
    bus_b.pal_waddr = 3'd0;
    bus_b.pal_wdata = 8'hFF;
    run_to(430);
    bus_b.pal_we = 1'b0;
    check("b_pal_old_value", read_sig(1, SIG_RGB), 'hBB);
    run_to(431);
    check("b_pal_new_value", read_sig(1, SIG_RGB), 'hFF);
    run_to(445);
    check("b_pal_other_entry", read_sig(1, SIG_RGB), 'h92);
    run_to(512);
    check("b_pal_new_row", read_sig(1, SIG_RGB), 'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
